// File: rtl/spi_adc_seq.sv
`default_nettype none
// ============================================================================
// Module      : spi_adc_seq
// Description : SAR ADC scan sequencer with channel mask, tick divider and
//               first-word-fall-through result FIFO with sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_adc_seq #(
    parameter  int ADC_WIDTH    = 12,
    parameter  int NUM_CH       = 4,
    parameter  int FIFO_DEPTH   = 8,
    parameter  int SAMPLE_TICKS = 2,
    localparam int CH_W         = $clog2(NUM_CH),
    localparam int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      sys_clk,
    input  logic                      reset_,
    input  logic                      en,
    input  logic                      start,
    input  logic                      auto,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic [15:0]               clk_div,
    input  logic                      comparator,
    input  logic                      rd_en,
    input  logic                      clr_overrun,
    output logic [CH_W-1:0]           ch_sel,
    output logic                      sample_and_hold,
    output logic                      pwr_gate,
    output logic [ADC_WIDTH-1:0]      dac,
    output logic                      busy,
    output logic                      eoc,
    output logic                      eos,
    output logic [CH_W+ADC_WIDTH-1:0] rd_data,
    output logic                      fifo_empty,
    output logic                      fifo_full,
    output logic [LVL_W-1:0]          fifo_level,
    output logic                      overrun
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_POWER   = 3'd1;
    localparam logic [2:0] ST_SAMPLE  = 3'd2;
    localparam logic [2:0] ST_CONVERT = 3'd3;
    localparam logic [2:0] ST_STORE   = 3'd4;

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BIT_W  = $clog2(ADC_WIDTH);
    localparam int SCNT_W = $clog2(SAMPLE_TICKS + 1);

    logic [2:0]              state_q,  state_d;
    logic [15:0]             cnt_q,    cnt_d;
    logic [NUM_CH-1:0]       mask_q,   mask_d;
    logic [CH_W-1:0]         ch_q,     ch_d;
    logic [SCNT_W-1:0]       scnt_q,   scnt_d;
    logic [BIT_W-1:0]        bit_q,    bit_d;
    logic [ADC_WIDTH-1:0]    dac_q,    dac_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q,  level_d;
    logic                    overrun_q, overrun_d;
    logic [CH_W+ADC_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic            tick, push, do_push, do_pop, drop;
    logic [CH_W:0]   first_ch, next_ch, relatch_ch;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] m, input int from);
        find_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && i >= from) find_ch = {1'b1, CH_W'(i)};
        end
    endfunction

    assign tick       = (state_q != ST_IDLE) && (cnt_q == clk_div);
    assign first_ch   = find_ch(mask_q, 0);
    assign next_ch    = find_ch(mask_q, int'(ch_q) + 1);
    assign relatch_ch = find_ch(ch_mask, 0);

    always_ff @(posedge sys_clk) begin
        if (!reset_) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            ch_q      <= '0;
            scnt_q    <= '0;
            bit_q     <= '0;
            dac_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            scnt_q    <= scnt_d;
            bit_q     <= bit_d;
            dac_q     <= dac_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {ch_q, dac_q};
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        scnt_d  = scnt_q;
        bit_d   = bit_q;
        dac_d   = dac_q;
        // STORE is a single-cycle phase; holding the counter there gives the
        // following SAMPLE a full tick period.
        if (state_q == ST_IDLE || state_q == ST_STORE) cnt_d = '0;
        else                                           cnt_d = tick ? '0 : cnt_q + 16'd1;
        if (!en) begin
            state_d = ST_IDLE;
            dac_d   = '0;
            ch_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dac_d = '0;
                    ch_d  = '0;
                    if (ch_mask != '0 && (start || auto)) begin
                        state_d = ST_POWER;
                        mask_d  = ch_mask;
                    end
                end
                ST_POWER: if (tick) begin
                    state_d = ST_SAMPLE;
                    ch_d    = first_ch[CH_W-1:0];
                    scnt_d  = '0;
                end
                ST_SAMPLE: if (tick) begin
                    if (scnt_q == SCNT_W'(SAMPLE_TICKS - 1)) begin
                        state_d = ST_CONVERT;
                        dac_d   = ADC_WIDTH'(1) << (ADC_WIDTH - 1);
                        bit_d   = BIT_W'(ADC_WIDTH - 1);
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                ST_CONVERT: if (tick) begin
                    if (!comparator) dac_d[bit_q] = 1'b0;
                    if (bit_q != '0) begin
                        dac_d[bit_q - 1'b1] = 1'b1;
                        bit_d               = bit_q - 1'b1;
                    end else begin
                        state_d = ST_STORE;
                    end
                end
                ST_STORE: begin
                    scnt_d = '0;
                    dac_d  = '0;
                    if (next_ch[CH_W]) begin
                        state_d = ST_SAMPLE;
                        ch_d    = next_ch[CH_W-1:0];
                    end else if (auto && relatch_ch[CH_W]) begin
                        state_d = ST_SAMPLE;
                        mask_d  = ch_mask;
                        ch_d    = relatch_ch[CH_W-1:0];
                    end else begin
                        state_d = ST_IDLE;
                        ch_d    = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy            = (state_q != ST_IDLE);
        pwr_gate        = busy;
        sample_and_hold = (state_q == ST_SAMPLE);
        ch_sel          = busy ? ch_q : '0;
        dac             = busy ? dac_q : '0;
        push            = (state_q == ST_STORE) && en && reset_;
        eoc             = push;
        eos             = push && !next_ch[CH_W];
    end

    // Result FIFO: a pop frees the slot for a same-cycle push when full.
    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
        fifo_level = level_q;
        overrun    = overrun_q;
        rd_data    = fifo_empty ? '0 : mem_q[rd_ptr_q];
        do_pop     = rd_en && !fifo_empty;
        do_push    = push && (!fifo_full || do_pop);
        drop       = push && fifo_full && !do_pop;
        wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        overrun_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_adc_seq
// Description : Randomized self-checking bench for spi_adc_seq against a
//               scan-level scoreboard of expected FIFO entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_adc_seq;

    logic        sys_clk = 1'b0;
    logic        reset_, en, start, auto, comparator, rd_en, clr_overrun;
    logic [3:0]  ch_mask;
    logic [15:0] clk_div;
    logic [1:0]  ch_sel;
    logic        sample_and_hold, pwr_gate, busy, eoc, eos;
    logic [11:0] dac;
    logic [13:0] rd_data;
    logic        fifo_empty, fifo_full, overrun;
    logic [3:0]  fifo_level;

    logic [11:0] vin_tab [4];
    logic [13:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    spi_adc_seq dut (
        .sys_clk(sys_clk), .reset_(reset_), .en(en), .start(start), .auto(auto),
        .ch_mask(ch_mask), .clk_div(clk_div), .comparator(comparator),
        .rd_en(rd_en), .clr_overrun(clr_overrun), .ch_sel(ch_sel),
        .sample_and_hold(sample_and_hold), .pwr_gate(pwr_gate), .dac(dac),
        .busy(busy), .eoc(eoc), .eos(eos), .rd_data(rd_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_level(fifo_level), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Analog front end: each channel holds a fixed input voltage.
    assign comparator = (vin_tab[ch_sel] >= dac);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic model_push(input logic [13:0] e);
        if (exp_q.size() < 8) exp_q.push_back(e);
    endtask

    task automatic model_scan(input logic [3:0] m);
        for (int c = 0; c < 4; c++)
            if (m[c]) model_push({c[1:0], vin_tab[c]});
    endtask

    task automatic wait_eoc(input int budget);
        int ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (eoc) begin ok = 1; break; end
            tick();
        end
        check("eoc_seen", ok, 1);
    endtask

    task automatic wait_eos(input int budget, output int n_eoc);
        int got = 0;
        n_eoc = 0;
        for (int c = 0; c < budget; c++) begin
            if (eoc) n_eoc++;
            if (eos) begin
                got = 1;
                check("eos_with_eoc", eoc, 1);
                break;
            end
            tick();
        end
        check("eos_seen", got, 1);
    endtask

    task automatic run_scan(input logic [3:0] m, input logic [15:0] div);
        int n;
        ch_mask = m;
        clk_div = div;
        pulse_start();
        check("busy_after_start", busy, 1);
        wait_eos(3000, n);
        check("eoc_count", n, $countones(m));
        tick();
        check("idle_after_scan", busy, 0);
        model_scan(m);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            check("fifo_level", fifo_level, exp_q.size());
            check("rd_data", rd_data, exp_q[0]);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            void'(exp_q.pop_front());
        end
        check("empty_after_drain", fifo_empty, 1);
    endtask

    initial begin
        int n;
        reset_ = 1'b0; en = 1'b0; start = 1'b0; auto = 1'b0;
        rd_en = 1'b0; clr_overrun = 1'b0; ch_mask = '0; clk_div = '0;
        for (int c = 0; c < 4; c++) vin_tab[c] = 12'($urandom);
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_pwr_gate", pwr_gate, 0);
        check("rst_sh", sample_and_hold, 0);
        check("rst_dac", dac, 0);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_eoc_eos", {eoc, eos}, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 0);
        reset_ = 1'b1;
        en     = 1'b1;
        tick();

        // Two-channel scan at full tick rate, fixed input 0xA5C.
        vin_tab[0] = 12'hA5C;
        vin_tab[2] = 12'hA5C;
        run_scan(4'b0101, 16'd0);
        check("a5c_head", rd_data, {2'd0, 12'hA5C});
        drain();

        // Latency from POWER entry to STORE with clk_div = 3.
        vin_tab[1] = 12'($urandom);
        ch_mask = 4'b0010;
        clk_div = 16'd3;
        pulse_start();
        check("power_pwr_gate", pwr_gate, 1);
        check("power_sh", sample_and_hold, 0);
        n = 0;
        while (!eoc && n < 500) begin
            tick();
            n++;
        end
        check("store_latency", n, 4 * (1 + 2 + 12));
        check("single_ch_eos", eos, 1);
        tick();
        check("idle_after_single", busy, 0);
        model_scan(4'b0010);
        drain();

        // Random masks, dividers and channel voltages.
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < 4; c++) vin_tab[c] = 12'($urandom);
            run_scan(4'($urandom_range(1, 15)), 16'($urandom_range(0, 3)));
            drain();
        end

        // Continuous scanning with no reads: fill, overflow, pop+push when full.
        vin_tab[0] = 12'($urandom);
        ch_mask = 4'b0001;
        clk_div = 16'd0;
        auto    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_eoc(200);
            model_push({2'd0, vin_tab[0]});
            tick();
            check("auto_level", fifo_level, k);
        end
        check("auto_full", fifo_full, 1);
        check("auto_no_overrun", overrun, 0);
        wait_eoc(200);
        tick();
        check("overrun_set", overrun, 1);
        check("level_held_full", fifo_level, 8);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("overrun_cleared", overrun, 0);
        wait_eoc(200);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        model_push({2'd0, vin_tab[0]});
        check("pop_push_level", fifo_level, 8);
        check("pop_push_no_overrun", overrun, 0);
        wait_eoc(200);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("overrun_set_wins", overrun, 1);
        auto = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("auto_stopped", busy, 0);
        drain();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("pop_empty_level", fifo_level, 0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;

        // Enable dropped mid-conversion keeps prior FIFO contents.
        for (int c = 0; c < 4; c++) vin_tab[c] = 12'($urandom) | 12'h001;
        run_scan(4'b0011, 16'd0);
        ch_mask = 4'b0001;
        clk_div = 16'd1;
        pulse_start();
        n = 0;
        while (!(busy && !sample_and_hold && dac != '0) && n < 200) begin
            tick();
            n++;
        end
        check("reached_convert", n < 200, 1);
        repeat (3) tick();
        en = 1'b0;
        check("en_low_no_eoc", eoc, 0);
        tick();
        check("en_low_busy", busy, 0);
        check("en_low_dac", dac, 0);
        check("en_low_pwr", pwr_gate, 0);
        en = 1'b1;
        repeat (5) tick();
        check("en_low_level", fifo_level, 2);
        drain();

        // Ignored starts: empty mask, and a second start while busy.
        ch_mask = 4'b0000;
        pulse_start();
        repeat (3) tick();
        check("start_mask0_idle", busy, 0);
        ch_mask = 4'b0001;
        clk_div = 16'd0;
        pulse_start();
        repeat (5) tick();
        ch_mask = 4'b1110;
        pulse_start();
        wait_eos(500, n);
        check("busy_start_eoc_count", n, 1);
        tick();
        check("busy_start_idle", busy, 0);
        model_scan(4'b0001);
        drain();

        // Reset in the middle of a scan.
        run_scan(4'b0001, 16'd0);
        ch_mask = 4'b1111;
        pulse_start();
        repeat (40) tick();
        reset_ = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_outputs", {pwr_gate, sample_and_hold, eoc, eos, overrun, fifo_full}, 0);
        check("midrst_dac_ch", {ch_sel, dac}, 0);
        check("midrst_empty", fifo_empty, 1);
        check("midrst_level", fifo_level, 0);
        check("midrst_rd_data", rd_data, 0);
        exp_q.delete();
        reset_ = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (eoc) n++;
        end
        check("postrst_no_eoc", n, 0);
        check("postrst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
